// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I fetch constants, fetch entry layout and PC alignment helper
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; push while full is accepted when a pop frees the slot
module fetch_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign empty = count == '0;
    assign full = count == CNT_W'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];

    // pointer and occupancy tracking; flush wins over push/pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // storage needs no reset; empty entries are never presented
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: fetch PC owner, credit-limited imem requester and decode-side instruction buffer
module instruction_fetch_buffer
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        misaligned_fault
);
    logic [31:0] fetch_pc, pend_pc;
    logic [CNT_W-1:0] outstanding, drop_count, fifo_count, pend_count;
    logic accept, rsp_keep, data_empty, data_full, pend_full, pend_empty;
    fetch_entry_t head;
    logic unused_ok;

    assign imem_req_valid = !redirect_valid && !misaligned_fault &&
                            ({1'b0, outstanding} + {1'b0, fifo_count} < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr = fetch_pc;
    assign accept = imem_req_valid && imem_req_ready;
    assign rsp_keep = imem_rsp_valid && drop_count == '0;
    assign inst_valid = !data_empty;
    assign instruction = data_empty ? NOP_INSTR : head.instr;
    assign inst_pc = data_empty ? '0 : head.pc;
    assign unused_ok = &{1'b0, data_full, pend_full, pend_empty, pend_count};

    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_data_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .flush(redirect_valid),
        .push(rsp_keep),
        .pop(inst_ready),
        .din({pend_pc, imem_rsp_data}),
        .dout(head),
        .full(data_full),
        .empty(data_empty),
        .count(fifo_count)
    );

    fetch_fifo #(.W(32), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_pend_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .flush(redirect_valid),
        .push(accept),
        .pop(rsp_keep),
        .din(fetch_pc),
        .dout(pend_pc),
        .full(pend_full),
        .empty(pend_empty),
        .count(pend_count)
    );

    // fetch PC, in-flight/drop bookkeeping and fault; a redirect turns every in-flight fetch into a drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            outstanding <= '0;
            drop_count <= '0;
            misaligned_fault <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            misaligned_fault <= |redirect_pc[1:0];
            outstanding <= outstanding - CNT_W'(imem_rsp_valid);
            drop_count <= outstanding - CNT_W'(imem_rsp_valid);
        end else begin
            if (accept) fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid && drop_count != '0) drop_count <= drop_count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb_instruction_fetch_buffer: randomized fetch traffic checked every cycle against a queue-based model
module tb_instruction_fetch_buffer;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk, reset_n;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic redirect_valid, inst_valid, inst_ready, misaligned_fault;
    logic [31:0] redirect_pc, instruction, inst_pc;

    instruction_fetch_buffer #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .instruction(instruction),
        .inst_pc(inst_pc),
        .misaligned_fault(misaligned_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit stale;
        int t;
    } req_t;

    req_t memq[$];
    logic [63:0] fq[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_dat[$];
    logic [31:0] m_pc;
    bit m_fault, m_req_valid;
    int cyc, checks, errors;

    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        return 32'h0010_0093 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic [31:0] e_ins, e_pc;
        e_ins = NOP;
        e_pc = 32'h0;
        if (fq.size() > 0) begin
            e_ins = fq[0][31:0];
            e_pc = fq[0][63:32];
        end
        m_req_valid = !redirect_valid && !m_fault && (memq.size() + fq.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(m_req_valid));
        chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(fq.size() > 0));
        chk("instruction", instruction, e_ins);
        chk("inst_pc", inst_pc, e_pc);
        chk("fault", 32'(misaligned_fault), 32'(m_fault));
    endtask

    task automatic model_update();
        bit acc, have;
        logic [63:0] ent;
        req_t r;
        acc = m_req_valid && imem_req_ready;
        have = 1'b0;
        ent = '0;
        if (imem_rsp_valid) begin
            r = memq.pop_front();
            if (!redirect_valid && !r.stale) begin
                have = 1'b1;
                ent = {r.addr, rsp_word(r.addr)};
            end
        end
        if (redirect_valid) begin
            fq.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            m_pc = {redirect_pc[31:2], 2'b00};
            m_fault = |redirect_pc[1:0];
        end else begin
            if (inst_ready && fq.size() > 0) begin
                pop_pc.push_back(fq[0][63:32]);
                pop_dat.push_back(fq[0][31:0]);
                void'(fq.pop_front());
            end
            if (have) fq.push_back(ent);
            if (acc) begin
                memq.push_back('{addr: m_pc, stale: 1'b0, t: cyc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input bit rdy, input bit rsp_en, input bit irdy, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        inst_ready = irdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        if (rsp_en && memq.size() > 0) begin
            if (memq[0].t < cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = rsp_word(memq[0].addr);
            end
        end
        #1 compare();
        @(posedge clk);
        model_update();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", 32'(misaligned_fault), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        memq.delete();
        fq.delete();
        pop_pc.delete();
        pop_dat.delete();
        m_pc = 32'h0;
        m_fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
        chk({name, "_avail"}, 32'(pop_pc.size() > idx), 32'h1);
        if (pop_pc.size() > idx) chk(name, pop_pc[idx], exp);
    endtask

    initial begin
        logic [31:0] rpc;
        checks = 0;
        errors = 0;
        cyc = 0;
        reset_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;

        // streaming from reset: PCs 0,4,8 in order with matching data
        do_reset();
        repeat (12) cycle(1, 1, 1, 0, 0);
        chk_pop("seq_pc0", 0, 32'h0);
        chk_pop("seq_pc1", 1, 32'h4);
        chk_pop("seq_pc2", 2, 32'h8);
        if (pop_dat.size() > 1) begin
            chk("seq_dat0", pop_dat[0], 32'h0010_0093);
            chk("seq_dat1", pop_dat[1], 32'h0010_0097);
        end

        // decoder stall: buffer fills, requests stop, head holds
        do_reset();
        repeat (6) cycle(1, 1, 0, 0, 0);
        #1;
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        chk("stall_head_pc", inst_pc, 32'h0);
        chk("stall_head_ins", instruction, 32'h0010_0093);
        repeat (12) cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) chk_pop("stall_resume_pc", i, 32'(4 * i));

        // redirect with two fetches in flight: both dropped
        do_reset();
        repeat (2) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h100);
        repeat (12) cycle(1, 1, 1, 0, 0);
        chk_pop("redir_pc", 0, 32'h100);
        if (pop_dat.size() > 0) chk("redir_dat", pop_dat[0], 32'h0010_0193);

        // redirect coinciding with a response and a pop
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 32'h300);
        #1;
        chk("coinc_inst_valid", 32'(inst_valid), 32'h0);
        repeat (8) cycle(1, 1, 1, 0, 0);
        chk_pop("coinc_pc", 0, 32'h300);

        // misaligned redirect halts fetch; aligned redirect recovers
        cycle(0, 1, 1, 1, 32'h102);
        repeat (4) cycle(1, 1, 1, 0, 0);
        #1;
        chk("mis_fault", 32'(misaligned_fault), 32'h1);
        chk("mis_req_valid", 32'(imem_req_valid), 32'h0);
        chk("mis_inst_valid", 32'(inst_valid), 32'h0);
        pop_pc.delete();
        pop_dat.delete();
        cycle(0, 1, 1, 1, 32'h200);
        repeat (8) cycle(1, 1, 1, 0, 0);
        #1;
        chk("recover_fault", 32'(misaligned_fault), 32'h0);
        chk_pop("recover_pc", 0, 32'h200);

        // randomized traffic with a mid-stream reset
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            rpc = $urandom;
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_buffer.md
Name: instruction_fetch_buffer

Overview:
Front-end fetch stage that sits directly upstream of the instruction decoder. It owns the fetch PC and issues word requests to instruction memory over a valid/ready handshake. It buffers in-order responses in a small FIFO and presents {instruction, pc} to decode over a valid/ready handshake. It also handles branch/jump redirects: it flushes buffered and in-flight fetches and restarts fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
CNT_W, 2, width of outstanding/drop/occupancy counters; must hold FIFO_DEPTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address (= fetch_pc)
imem_rsp_valid  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance
imem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  one-cycle redirect pulse from branch/jump resolution
redirect_pc  input  32  redirect target
inst_valid  output  1  FIFO head valid toward decoder
inst_ready  input  1  decoder consumes head this cycle
instruction  output  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty
inst_pc  output  32  PC of FIFO head; 0 when empty
misaligned_fault  output  1  sticky: redirect target had pc[1:0] != 0

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_count = 0; misaligned_fault = 0.
  - Outputs: inst_valid = 0, instruction = NOP, inst_pc = 0.
  - An assert mid-transaction discards everything; responses to pre-reset requests are not expected by the bench.
- Request issue (combinational):
  - imem_req_valid = !redirect_valid && !misaligned_fault && (outstanding + fifo_count < FIFO_DEPTH).
  - This credit rule guarantees FIFO space for every response, so the FIFO never overflows.
- Request accept (imem_req_valid && imem_req_ready):
  - fetch_pc += 4, wrapping modulo 2^32.
  - outstanding +1.
- Response (imem_rsp_valid):
  - outstanding -1.
  - If drop_count > 0: drop_count -1 and data discarded.
  - Else: push {imem_rsp_data, pc}, where pc comes from a pending-PC queue of depth FIFO_DEPTH captured at request accept.
- Accept and response in the same cycle: outstanding unchanged.
- Throughput and latency:
  - Response at edge N appears on inst_valid after edge N (registered, 1-cycle latency).
  - Steady state is 1 instruction/cycle when memory is single-cycle and inst_ready stays high.
- Decode handshake:
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Outputs are stable while inst_valid && !inst_ready.
- Redirect (redirect_valid high at an edge), takes priority over all other updates that cycle:
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO and pending-PC queue flushed.
  - drop_count = outstanding, minus 1 if a response arrives that cycle (that response is itself dropped).
  - No request is issued in the redirect cycle.
  - Pop that cycle is ignored; inst_valid = 0 on the following cycle.
  - If redirect_pc[1:0] != 0: misaligned_fault = 1 and fetch halts.
    - Fault clears only on a later aligned redirect or on reset.
    - inst_valid stays 0 while the fault is set, after the FIFO drains.
- A redirect arriving while drop_count > 0 accumulates: the new drop_count is all remaining outstanding requests.
- Empty FIFO: inst_valid = 0, instruction = NOP.

Decomposition:
- rv32i_pkg holds: XLEN = 32, NOP_INSTR = 32'h0000_0013, PC_STEP = 4, RESET_PC default.
- One sub-module: fetch_fifo, a synchronous FIFO of width 64 ({pc, instruction}) with flush, push, pop, full, empty and count.
- Instantiate fetch_fifo twice: once for responses and once, at width 32, for pending PCs.
- Counters and credit logic stay in the top module.

Test Plan:
- Reset release, imem ready always, response 1 cycle after accept with data = 0x00100093 + addr -> requests at 0x0, 0x4, 0x8…; inst_valid from cycle 2; inst_pc sequence 0x0, 0x4, 0x8; one instruction per cycle.
- inst_ready held low 5 cycles -> at most FIFO_DEPTH requests outstanding plus buffered; imem_req_valid drops; head stays 0x0/0x00100093 unchanged; release resumes in order with no loss or duplication.
- Redirect to 0x100 with 2 requests in flight -> both responses dropped (drop_count 2→0); next inst_pc = 0x100; no stale PC ever presented.
- Redirect in the same cycle as a response and a decoder pop -> response dropped; FIFO empty the next cycle; fetch restarts at target.
- Redirect to 0x102 -> misaligned_fault = 1; no further requests; then a redirect to 0x200 -> fault clears and fetch resumes at 0x200.
- Assert reset_n low mid-stream -> all outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC.
